wr_first_edge_bram: RTL and testbench

Loader that fills the per-core first-edge (CSR offset) BRAM banks before a BFS run. Sits opposite rd_first_edge_bram on the same memories: this block writes them, and the pipeline read stage reads them.
Takes a valid/ready stream of first-edge values in vertex-id order. Vertex v goes to bank v mod CORE_NUM at address v / CORE_NUM, so the interleaving matches the read-side core partitioning.
Reports busy, a done pulse and a capacity error to the host control logic.

---
 rtl/wr_first_edge_bram_pkg.sv | 23 ++
 rtl/wr_first_edge_bram.sv | 111 +++++++++++
 tb/tb_wr_first_edge_bram.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wr_first_edge_bram_pkg.sv
// Shared definitions for the first-edge BRAM loader: FSM states and the
// bank capacity derived from core count and per-bank address width.
package wr_first_edge_bram_pkg;

    localparam int unsigned V_ID_WIDTH_DEF             = 32;
    localparam int unsigned FIRST_EDGE_BRAM_AWIDTH_DEF = 11;
    localparam int unsigned FIRST_EDGE_BRAM_DWIDTH_DEF = 32;
    localparam int unsigned CORE_NUM_DEF               = 16;
    localparam int unsigned CORE_NUM_WIDTH_DEF         = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } load_state_e;

    // Total entries across all banks; 64-bit so large parameter sets never wrap.
    function automatic logic [63:0] capacity(input int unsigned core_num,
                                             input int unsigned awidth);
        return 64'(core_num) << awidth;
    endfunction

endpackage

// File: rtl/wr_first_edge_bram.sv
// Streams first-edge values into CORE_NUM interleaved BRAM banks: vertex v
// lands in bank v mod CORE_NUM at address v / CORE_NUM.
module wr_first_edge_bram
    import wr_first_edge_bram_pkg::*;
#(
    parameter int unsigned V_ID_WIDTH             = V_ID_WIDTH_DEF,
    parameter int unsigned FIRST_EDGE_BRAM_AWIDTH = FIRST_EDGE_BRAM_AWIDTH_DEF,
    parameter int unsigned FIRST_EDGE_BRAM_DWIDTH = FIRST_EDGE_BRAM_DWIDTH_DEF,
    parameter int unsigned CORE_NUM               = CORE_NUM_DEF,
    parameter int unsigned CORE_NUM_WIDTH         = CORE_NUM_WIDTH_DEF
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       load_start,
    input  logic [V_ID_WIDTH-1:0]                      load_v_num,
    input  logic [FIRST_EDGE_BRAM_DWIDTH-1:0]          s_data,
    input  logic                                       s_valid,
    output logic                                       s_ready,
    output logic [CORE_NUM-1:0]                        bram_we,
    output logic [CORE_NUM*FIRST_EDGE_BRAM_AWIDTH-1:0] bram_addr,
    output logic [CORE_NUM*FIRST_EDGE_BRAM_DWIDTH-1:0] bram_din,
    output logic                                       load_busy,
    output logic                                       load_done,
    output logic                                       load_err
);

    localparam logic [V_ID_WIDTH:0] CAP =
        (V_ID_WIDTH+1)'(capacity(CORE_NUM, FIRST_EDGE_BRAM_AWIDTH));

    load_state_e                        state;
    load_state_e                        state_next;
    logic [V_ID_WIDTH-1:0]              idx;
    logic [V_ID_WIDTH-1:0]              v_num;
    logic [FIRST_EDGE_BRAM_AWIDTH-1:0]  addr;
    logic [FIRST_EDGE_BRAM_DWIDTH-1:0]  din;
    logic                               accept_c;
    logic                               last_beat_c;
    logic                               over_cap_c;
    logic                               start_c;

    assign accept_c    = s_valid && s_ready;
    assign last_beat_c = accept_c && (idx == (v_num - V_ID_WIDTH'(1)));
    assign over_cap_c  = {1'b0, load_v_num} > CAP;
    assign start_c     = (state == IDLE) && load_start;

    // Every lane sees the same address/data; only the one-hot enable selects the bank.
    assign bram_addr = {CORE_NUM{addr}};
    assign bram_din  = {CORE_NUM{din}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (load_start) begin
                    if ((load_v_num == '0) || over_cap_c) begin
                        state_next = DONE;
                    end else begin
                        state_next = LOAD;
                    end
                end
            end
            LOAD: begin
                if (last_beat_c) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status flags are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_ready   <= 1'b0;
            load_busy <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            bram_we   <= '0;
            addr      <= '0;
            din       <= '0;
            idx       <= '0;
            v_num     <= '0;
        end else begin
            s_ready   <= (state_next == LOAD);
            load_busy <= (state_next != IDLE);
            load_done <= (state_next == DONE);
            bram_we   <= '0;
            if (accept_c) begin
                bram_we <= CORE_NUM'(1) << idx[CORE_NUM_WIDTH-1:0];
                addr    <= idx[CORE_NUM_WIDTH +: FIRST_EDGE_BRAM_AWIDTH];
                din     <= s_data;
                idx     <= idx + V_ID_WIDTH'(1);
            end
            if (start_c) begin
                v_num    <= load_v_num;
                idx      <= '0;
                load_err <= over_cap_c;
            end
        end
    end

endmodule

// File: tb/tb_wr_first_edge_bram.sv
// Randomised bench for wr_first_edge_bram; expected writes come from the
// vertex-to-bank interleaving rule applied to a running count of accepted beats.
module tb_wr_first_edge_bram;

    localparam int unsigned NC  = 16;
    localparam int unsigned AW  = 11;
    localparam int unsigned DW  = 32;
    localparam logic [63:0] CAP = 64'(NC) << AW;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            load_start = 1'b0;
    logic [31:0]     load_v_num = '0;
    logic [DW-1:0]   s_data = '0;
    logic            s_valid = 1'b0;
    logic            s_ready;
    logic [NC-1:0]   bram_we;
    logic [NC*AW-1:0] bram_addr;
    logic [NC*DW-1:0] bram_din;
    logic            load_busy;
    logic            load_done;
    logic            load_err;

    int unsigned checks = 0;
    int unsigned passed = 0;
    logic [AW-1:0] last_addr = '0;
    logic [DW-1:0] last_din = '0;

    wr_first_edge_bram dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .load_v_num (load_v_num),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .bram_we    (bram_we),
        .bram_addr  (bram_addr),
        .bram_din   (bram_din),
        .load_busy  (load_busy),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    // One complete load: drives the stream and checks every output on every cycle.
    task automatic run_load(input string tag, input logic [31:0] vn, input int gap_pct,
                            input bit rand_data, input logic [31:0] base,
                            input int gap_after, input bit glitch);
        int unsigned   nbeats;
        int unsigned   k;
        int            gap_left;
        int            budget;
        bit            exp_err;
        bit            exp_done;
        bit            exp_ready;
        bit            prev_acc;
        bit            finished;
        logic [NC-1:0] exp_we;
        logic [DW-1:0] prev_data;
        exp_err  = {32'h0, vn} > CAP;
        nbeats   = (exp_err || vn == 0) ? 0 : vn;
        k        = 0;
        gap_left = 0;
        prev_acc = 1'b0;
        finished = 1'b0;
        prev_data = '0;
        budget   = 4 * int'(nbeats) + 20;
        @(negedge clk);
        load_start = 1'b1;
        load_v_num = vn;
        s_valid    = 1'b1;
        s_data     = $urandom;
        for (int cyc = 0; cyc < budget && !finished; cyc++) begin
            @(negedge clk);
            load_start = 1'b0;
            load_v_num = $urandom;
            if (prev_acc) begin
                exp_we    = NC'(1) << ((k - 1) % NC);
                last_addr = AW'((k - 1) / NC);
                last_din  = prev_data;
            end else begin
                exp_we = '0;
            end
            exp_done  = (nbeats == 0) ? (cyc == 0) : (prev_acc && k == nbeats);
            exp_ready = (k < nbeats);
            checks++;
            if ({bram_we, bram_addr, bram_din, load_done, s_ready, load_busy, load_err} !==
                {exp_we, {NC{last_addr}}, {NC{last_din}}, exp_done, exp_ready, 1'b1, exp_err}) begin
                $display("FAIL %s cyc=%0d got we=%h a0=%h d0=%h done=%b rdy=%b busy=%b err=%b want we=%h a=%h d=%h done=%b rdy=%b busy=1 err=%b",
                         tag, cyc, bram_we, bram_addr[AW-1:0], bram_din[DW-1:0], load_done, s_ready,
                         load_busy, load_err, exp_we, last_addr, last_din, exp_done, exp_ready, exp_err);
            end else begin
                passed++;
            end
            if (exp_done) finished = 1'b1;
            if (glitch && cyc == 2) begin
                load_start = 1'b1;
                load_v_num = 32'd0;
            end
            if (gap_left > 0) begin
                s_valid = 1'b0;
                gap_left--;
            end else begin
                s_valid = ($urandom_range(99) >= gap_pct);
            end
            s_data   = rand_data ? $urandom : base + k;
            prev_acc = s_valid && exp_ready;
            if (prev_acc) begin
                prev_data = s_data;
                k++;
                if (gap_after >= 0 && k == unsigned'(gap_after + 1)) gap_left = 2;
            end
        end
        if (!finished) begin
            checks++;
            $display("FAIL %s timeout: no done after %0d cycles, beats=%0d want %0d", tag, budget, k, nbeats);
        end
        @(negedge clk);
        load_start = 1'b0;
        checks++;
        if ({bram_we, load_done, s_ready, load_busy, load_err} !== {NC'(0), 3'b000, exp_err}) begin
            $display("FAIL %s after-done got we=%h done=%b rdy=%b busy=%b err=%b want we=0 done=0 rdy=0 busy=0 err=%b",
                     tag, bram_we, load_done, s_ready, load_busy, load_err, exp_err);
        end else begin
            passed++;
        end
        s_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        load_start = 1'b1;
        load_v_num = 32'd5;
        s_valid    = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if ({bram_we, bram_addr, bram_din, s_ready, load_busy, load_done, load_err} !== '0) begin
            $display("FAIL reset_hold got we=%h rdy=%b busy=%b done=%b err=%b want all 0",
                     bram_we, s_ready, load_busy, load_done, load_err);
        end else begin
            passed++;
        end
        load_start = 1'b0;
        s_valid    = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({bram_we, bram_addr, bram_din, s_ready, load_busy, load_done, load_err} !== '0) begin
                $display("FAIL reset_release%0d got we=%h rdy=%b busy=%b done=%b err=%b want all 0",
                         i, bram_we, s_ready, load_busy, load_done, load_err);
            end else begin
                passed++;
            end
        end
        last_addr = '0;
        last_din  = '0;
    endtask

    task automatic test_back_to_back();
        run_load("b2b_v3", 32'd3, 0, 1'b0, 32'h10, -1, 1'b0);
        run_load("b2b_v17", 32'd17, 0, 1'b0, 32'h0, -1, 1'b0);
    endtask

    task automatic test_gap();
        run_load("gap_v4", 32'd4, 0, 1'b0, 32'h100, 1, 1'b0);
    endtask

    task automatic test_capacity();
        run_load("cap_zero", 32'd0, 0, 1'b1, 32'h0, -1, 1'b0);
        run_load("cap_over", 32'd32769, 0, 1'b1, 32'h0, -1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (load_err !== 1'b1) begin
                $display("FAIL cap_sticky%0d got err=%b want 1", i, load_err);
            end else begin
                passed++;
            end
        end
        run_load("cap_clear", 32'd3, 20, 1'b1, 32'h0, -1, 1'b0);
        run_load("cap_full", 32'd32768, 0, 1'b1, 32'h0, -1, 1'b0);
    endtask

    task automatic test_reset_midload();
        @(negedge clk);
        load_start = 1'b1;
        load_v_num = 32'd10;
        s_valid    = 1'b0;
        @(negedge clk);
        load_start = 1'b0;
        s_valid    = 1'b1;
        repeat (5) begin
            s_data = $urandom;
            @(negedge clk);
        end
        s_valid = 1'b0;
        checks++;
        if (bram_we !== 16'h0010) begin
            $display("FAIL midload_beat5 got we=%h want 0010", bram_we);
        end else begin
            passed++;
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bram_we, bram_addr, bram_din, s_ready, load_busy, load_done, load_err} !== '0) begin
            $display("FAIL midload_async got we=%h rdy=%b busy=%b done=%b err=%b want all 0",
                     bram_we, s_ready, load_busy, load_done, load_err);
        end else begin
            passed++;
        end
        last_addr = '0;
        last_din  = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_load("restart_v2", 32'd2, 0, 1'b1, 32'h0, -1, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            run_load("random", 32'($urandom_range(40, 1)), int'($urandom_range(50)),
                     1'b1, 32'h0, -1, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gap();
        test_capacity();
        test_reset_midload();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
